// File: rtl/round_result_mux.sv
// Round-stage result collector: arbitrates NCH channel strobes onto one
// registered output word, with fixed-priority or round-robin selection.
module round_result_mux #(
  parameter int WIDTH = 128,
  parameter int NCH   = 4,
  parameter int ARB   = 0,
  parameter int SW    = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SW-1:0]        out_src,
  input  logic                 out_ready,
  output logic                 err_multi,
  input  logic                 err_clr
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SW-1:0]    r_out_src;
  logic             r_err_multi;
  logic [SW-1:0]    r_rr_ptr;

  logic             w_can_accept;
  logic             w_grant_vld;
  logic [SW-1:0]    w_grant_idx;
  logic [NCH-1:0]   w_ready;
  logic             w_in_xfer;
  logic             w_multi;
  logic [WIDTH-1:0] w_sel_data;
  logic [SW-1:0]    w_rr_next;

  assign w_can_accept = !r_out_valid || out_ready;

  // Search starts at rr_ptr in round-robin mode, at channel 0 otherwise.
  always_comb begin
    int          v_idx;
    logic [SW-1:0] v_cand;
    v_idx       = 0;
    v_cand      = '0;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      v_idx  = (ARB == 1) ? ((int'(r_rr_ptr) + k) % NCH) : k;
      v_cand = SW'(v_idx);
      if (!w_grant_vld && in_valid[v_cand]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = v_cand;
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (w_grant_vld && w_can_accept && !rst) begin
      w_ready[w_grant_idx] = 1'b1;
    end
  end

  assign w_in_xfer  = w_grant_vld && w_can_accept;
  assign w_multi    = ($countones(in_valid) > 1);
  assign w_sel_data = in_data[int'(w_grant_idx)*WIDTH +: WIDTH];
  assign w_rr_next  = (w_grant_idx == SW'(NCH - 1)) ? '0 : (w_grant_idx + 1'b1);

  // Output register stage: load on input transfer, drain on output transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else if (w_in_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_src   <= w_grant_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // A collision in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_multi <= 1'b0;
    end else if (w_multi) begin
      r_err_multi <= 1'b1;
    end else if (err_clr) begin
      r_err_multi <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if ((ARB == 1) && w_in_xfer) begin
      r_rr_ptr <= w_rr_next;
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign err_multi = r_err_multi;

endmodule

// File: tb/tb_round_result_mux.sv
// Directed bench for round_result_mux: fixed-priority and round-robin
// instances at default size, plus NCH=2/WIDTH=8 and NCH=16/WIDTH=128.
module tb_round_result_mux;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  // A: NCH=4 WIDTH=128 ARB=0
  logic [3:0]   a_valid;
  logic [511:0] a_data;
  logic [3:0]   a_ready;
  logic         a_ovalid;
  logic [127:0] a_odata;
  logic [1:0]   a_osrc;
  logic         a_oready;
  logic         a_err;
  logic         a_clr;
  // B: NCH=4 WIDTH=128 ARB=1
  logic [3:0]   b_valid;
  logic [511:0] b_data;
  logic [3:0]   b_ready;
  logic         b_ovalid;
  logic [127:0] b_odata;
  logic [1:0]   b_osrc;
  logic         b_oready;
  logic         b_err;
  logic         b_clr;
  // C: NCH=2 WIDTH=8 ARB=0
  logic [1:0]   c_valid;
  logic [15:0]  c_data;
  logic [1:0]   c_ready;
  logic         c_ovalid;
  logic [7:0]   c_odata;
  logic [0:0]   c_osrc;
  logic         c_oready;
  logic         c_err;
  logic         c_clr;
  // D: NCH=16 WIDTH=128 ARB=1
  logic [15:0]   d_valid;
  logic [2047:0] d_data;
  logic [15:0]   d_ready;
  logic          d_ovalid;
  logic [127:0]  d_odata;
  logic [3:0]    d_osrc;
  logic          d_oready;
  logic          d_err;
  logic          d_clr;

  round_result_mux #(.WIDTH(128), .NCH(4), .ARB(0)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_data(a_data), .in_ready(a_ready),
    .out_valid(a_ovalid), .out_data(a_odata), .out_src(a_osrc), .out_ready(a_oready),
    .err_multi(a_err), .err_clr(a_clr));

  round_result_mux #(.WIDTH(128), .NCH(4), .ARB(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_data(b_data), .in_ready(b_ready),
    .out_valid(b_ovalid), .out_data(b_odata), .out_src(b_osrc), .out_ready(b_oready),
    .err_multi(b_err), .err_clr(b_clr));

  round_result_mux #(.WIDTH(8), .NCH(2), .ARB(0)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_data(c_data), .in_ready(c_ready),
    .out_valid(c_ovalid), .out_data(c_odata), .out_src(c_osrc), .out_ready(c_oready),
    .err_multi(c_err), .err_clr(c_clr));

  round_result_mux #(.WIDTH(128), .NCH(16), .ARB(1)) u_d (
    .clk(clk), .rst(rst), .in_valid(d_valid), .in_data(d_data), .in_ready(d_ready),
    .out_valid(d_ovalid), .out_data(d_odata), .out_src(d_osrc), .out_ready(d_oready),
    .err_multi(d_err), .err_clr(d_clr));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] dword(input int ch);
    logic [15:0] v;
    v = 16'hC000 + 16'(ch);
    return {8{v}};
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    a_valid = 4'b0001; a_data = '0; a_oready = 1'b1; a_clr = 1'b0;
    b_valid = '0; b_data = '0; b_oready = 1'b1; b_clr = 1'b0;
    c_valid = '0; c_data = '0; c_oready = 1'b1; c_clr = 1'b0;
    d_valid = '0; d_data = '0; d_oready = 1'b1; d_clr = 1'b0;
    #1;
    chk("rst_ovalid", 128'(a_ovalid), 128'd0);
    chk("rst_odata", a_odata, 128'd0);
    chk("rst_osrc", 128'(a_osrc), 128'd0);
    chk("rst_err", 128'(a_err), 128'd0);
    chk("rst_ready", 128'(a_ready), 128'd0);
    tick();
    tick();
    rst = 1'b0;
    a_valid = 4'b0000;
    tick();

    // single channel
    a_valid = 4'b0100;
    a_data[2*128 +: 128] = {16{8'hA5}};
    #1;
    chk("single_ready", 128'(a_ready), 128'h4);
    tick();
    chk("single_ovalid", 128'(a_ovalid), 128'd1);
    chk("single_odata", a_odata, {16{8'hA5}});
    chk("single_osrc", 128'(a_osrc), 128'd2);
    chk("single_err", 128'(a_err), 128'd0);
    a_valid = 4'b0000;
    tick();
    chk("drain_ovalid", 128'(a_ovalid), 128'd0);
    chk("drain_hold", a_odata, {16{8'hA5}});

    // backpressure
    a_valid = 4'b1000;
    a_data[3*128 +: 128] = {16{8'h33}};
    a_oready = 1'b0;
    tick();
    chk("bp_load", a_odata, {16{8'h33}});
    a_valid = 4'b0001;
    a_data[0 +: 128] = {16{8'h11}};
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_ready_%0d", i), 128'(a_ready), 128'd0);
      tick();
      chk($sformatf("bp_odata_%0d", i), a_odata, {16{8'h33}});
      chk($sformatf("bp_osrc_%0d", i), 128'(a_osrc), 128'd3);
      chk($sformatf("bp_ovalid_%0d", i), 128'(a_ovalid), 128'd1);
    end
    a_oready = 1'b1;
    #1;
    chk("bp_release_ready", 128'(a_ready), 128'h1);
    tick();
    chk("bp_ch0_data", a_odata, {16{8'h11}});
    chk("bp_ch0_src", 128'(a_osrc), 128'd0);
    a_data[0 +: 128] = {16{8'h22}};
    tick();
    chk("thru_ovalid", 128'(a_ovalid), 128'd1);
    chk("thru_odata", a_odata, {16{8'h22}});
    a_valid = 4'b0000;
    tick();
    chk("thru_drain", 128'(a_ovalid), 128'd0);

    // collision, fixed priority
    a_valid = 4'b1010;
    a_data[1*128 +: 128] = {16{8'h01}};
    a_data[3*128 +: 128] = {16{8'h03}};
    #1;
    chk("col_ready", 128'(a_ready), 128'h2);
    tick();
    chk("col_osrc", 128'(a_osrc), 128'd1);
    chk("col_odata", a_odata, {16{8'h01}});
    chk("col_err", 128'(a_err), 128'd1);
    a_valid = 4'b1000;
    tick();
    chk("col_ch3_src", 128'(a_osrc), 128'd3);
    chk("col_err_sticky", 128'(a_err), 128'd1);
    a_valid = 4'b0001;
    a_clr = 1'b1;
    tick();
    chk("clr_err", 128'(a_err), 128'd0);
    a_valid = 4'b0011;
    tick();
    chk("set_beats_clr", 128'(a_err), 128'd1);
    a_valid = 4'b0000;
    tick();
    chk("clr_err2", 128'(a_err), 128'd0);
    a_clr = 1'b0;

    // round robin
    for (int i = 0; i < 4; i++) b_data[i*128 +: 128] = {16{8'(8'hB0 + i)}};
    b_valid = 4'b1111;
    #1;
    chk("rr_ready0", 128'(b_ready), 128'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rr_src_%0d", i), 128'(b_osrc), 128'(i % 4));
      chk($sformatf("rr_data_%0d", i), b_odata, {16{8'(8'hB0 + (i % 4))}});
    end
    b_oready = 1'b0;
    #1;
    chk("rr_stall_ready", 128'(b_ready), 128'd0);
    tick();
    chk("rr_stall_src", 128'(b_osrc), 128'd0);
    b_oready = 1'b1;
    tick();
    chk("rr_resume_src", 128'(b_osrc), 128'd1);
    b_valid = 4'b1001;
    tick();
    chk("rr_skip_src", 128'(b_osrc), 128'd3);
    b_valid = 4'b0110;
    tick();
    chk("rr_wrap_src", 128'(b_osrc), 128'd1);

    // async reset between edges
    a_valid = 4'b0110;
    tick();
    chk("ar_pre_ovalid", 128'(a_ovalid), 128'd1);
    chk("ar_pre_err", 128'(a_err), 128'd1);
    a_valid = 4'b0100;
    b_valid = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_ovalid", 128'(a_ovalid), 128'd0);
    chk("ar_odata", a_odata, 128'd0);
    chk("ar_osrc", 128'(a_osrc), 128'd0);
    chk("ar_err", 128'(a_err), 128'd0);
    chk("ar_ready", 128'(a_ready), 128'd0);
    #1;
    rst = 1'b0;
    tick();
    chk("ar_first_accept", 128'(a_ovalid), 128'd1);
    chk("ar_first_src", 128'(a_osrc), 128'd2);
    chk("ar_rr_restart", 128'(b_osrc), 128'd0);
    a_valid = 4'b0000;
    b_valid = 4'b0000;

    // NCH=2, WIDTH=8
    c_valid = 2'b10;
    c_data = 16'hA500;
    #1;
    chk("c_single_ready", 128'(c_ready), 128'h2);
    tick();
    chk("c_single_data", 128'(c_odata), 128'hA5);
    chk("c_single_src", 128'(c_osrc), 128'd1);
    chk("c_single_err", 128'(c_err), 128'd0);
    c_oready = 1'b0;
    c_valid = 2'b01;
    c_data = 16'h005A;
    #1;
    chk("c_bp_ready", 128'(c_ready), 128'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("c_bp_data_%0d", i), 128'(c_odata), 128'hA5);
    end
    c_oready = 1'b1;
    #1;
    chk("c_bp_release", 128'(c_ready), 128'h1);
    tick();
    chk("c_bp_ch0", 128'(c_odata), 128'h5A);
    chk("c_bp_src0", 128'(c_osrc), 128'd0);
    c_valid = 2'b11;
    c_data = 16'h3CC3;
    #1;
    chk("c_col_ready", 128'(c_ready), 128'h1);
    tick();
    chk("c_col_data", 128'(c_odata), 128'hC3);
    chk("c_col_err", 128'(c_err), 128'd1);
    c_valid = 2'b10;
    tick();
    chk("c_col_ch1", 128'(c_odata), 128'h3C);
    chk("c_col_sticky", 128'(c_err), 128'd1);
    c_valid = 2'b01;
    c_clr = 1'b1;
    tick();
    chk("c_clr", 128'(c_err), 128'd0);
    c_valid = 2'b00;
    c_clr = 1'b0;

    // NCH=16, round robin
    for (int i = 0; i < 16; i++) d_data[i*128 +: 128] = dword(i);
    d_valid = 16'hFFFF;
    #1;
    chk("d_ready0", 128'(d_ready), 128'h1);
    for (int i = 0; i < 17; i++) begin
      tick();
      chk($sformatf("d_rr_src_%0d", i), 128'(d_osrc), 128'(i % 16));
      chk($sformatf("d_rr_data_%0d", i), d_odata, dword(i % 16));
    end
    chk("d_err", 128'(d_err), 128'd1);
    d_oready = 1'b0;
    #1;
    chk("d_stall_ready", 128'(d_ready), 128'd0);
    tick();
    chk("d_stall_src", 128'(d_osrc), 128'd0);
    d_oready = 1'b1;
    d_valid = 16'h0200;
    tick();
    chk("d_single_src", 128'(d_osrc), 128'd9);
    chk("d_single_data", d_odata, dword(9));
    d_valid = 16'h0000;
    d_clr = 1'b1;
    tick();
    chk("d_clr", 128'(d_err), 128'd0);
    chk("d_drain", 128'(d_ovalid), 128'd0);
    d_clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
